// File: rtl/exmem_pkg.sv
// Shared constants, default widths and the entry layout for the EX/MEM skid register.
package exmem_pkg;
    localparam int DBITS_DEF               = 32;
    localparam int REG_INDEX_BIT_WIDTH_DEF = 4;
    localparam int FUNC_BITS_DEF           = 4;
    localparam int OP_BITS_DEF             = 4;

    localparam logic [3:0] ALUR = 4'b1100;
    localparam logic [3:0] ADD  = 4'b0111;

    // Field order here is the packing order used for the flat slot vector (wrMem at bit 0).
    typedef struct packed {
        logic [FUNC_BITS_DEF-1:0]           func;
        logic [OP_BITS_DEF-1:0]             op;
        logic [DBITS_DEF-1:0]               regData2;
        logic [DBITS_DEF-1:0]               intermediateResult;
        logic [REG_INDEX_BIT_WIDTH_DEF-1:0] rs2;
        logic [REG_INDEX_BIT_WIDTH_DEF-1:0] rd;
        logic                               ME_mux_sel;
        logic                               wrReg;
        logic                               wrMem;
    } entry_t;
endpackage

// File: rtl/exmem_slot.sv
// One entry register with valid bit, flush and optional store-data forwarding (EXMEM_FWD_EN).
module exmem_slot
    import exmem_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int RIB   = REG_INDEX_BIT_WIDTH_DEF,
    parameter int W     = 83
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             drain,
    input  logic [W-1:0]     d,
`ifdef EXMEM_FWD_EN
    input  logic             wb_wrReg,
    input  logic [RIB-1:0]   wb_rd,
    input  logic [DBITS-1:0] wb_data,
`endif
    output logic [W-1:0]     q,
    output logic             valid
);
`ifdef EXMEM_FWD_EN
    localparam int RS2_LO = 3 + RIB;
    localparam int D2_LO  = 3 + 2*RIB + DBITS;
`endif

    // Store data of a store whose rs2 is being written back this cycle is replaced.
    function automatic logic [W-1:0] fwd(input logic [W-1:0] e);
        fwd = e;
`ifdef EXMEM_FWD_EN
        if (wb_wrReg && e[0] && (e[RS2_LO +: RIB] == wb_rd))
            fwd[D2_LO +: DBITS] = wb_data;
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= fwd(d);
        end else begin
            if (drain) valid <= 1'b0;
            if (valid) q <= fwd(q);
        end
    end
endmodule

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional write-back forwarding into held store data when EXMEM_FWD_EN is defined.
module exmem_skid_reg
    import exmem_pkg::*;
#(
    parameter int DBITS               = DBITS_DEF,
    parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEF,
    parameter int FUNC_BITS           = FUNC_BITS_DEF,
    parameter int OP_BITS             = OP_BITS_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FUNC_BITS-1:0]           func,
    input  logic [OP_BITS-1:0]             op,
    input  logic [DBITS-1:0]               regData2,
    input  logic [DBITS-1:0]               intermediateResult,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
    input  logic                           ME_mux_sel,
    input  logic                           wrReg,
    input  logic                           wrMem,
`ifdef EXMEM_FWD_EN
    input  logic                           wb_wrReg,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd,
    input  logic [DBITS-1:0]               wb_data,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [FUNC_BITS-1:0]           EX_func,
    output logic [OP_BITS-1:0]             EX_op,
    output logic [DBITS-1:0]               EX_regData2,
    output logic [DBITS-1:0]               EX_intermediateResult,
    output logic [REG_INDEX_BIT_WIDTH-1:0] EX_rs2,
    output logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
    output logic                           EX_ME_mux_sel,
    output logic                           EX_wrReg,
    output logic                           EX_wrMem
);
    localparam int W = FUNC_BITS + OP_BITS + 2*DBITS + 2*REG_INDEX_BIT_WIDTH + 3;

    logic [W-1:0] in_entry, main_d, main_q, skid_q;
    logic         main_v, skid_v;
    logic         accept, consume, main_load, skid_load, skid_drain;
    logic         wr_q, wm_q;

    assign in_entry = {func, op, regData2, intermediateResult, rs2, rd, ME_mux_sel, wrReg, wrMem};

    // in_ready is a pure function of the skid valid flop, so out_ready never reaches it.
    assign in_ready = !skid_v;
    assign accept   = in_valid && in_ready;
    assign consume  = main_v && out_ready;

    // Main refills whenever it is free or draining; the older skid entry goes first.
    assign main_load  = (!main_v || consume) && (skid_v || accept);
    assign main_d     = skid_v ? skid_q : in_entry;
    assign skid_load  = accept && (skid_v || (main_v && !consume));
    assign skid_drain = skid_v && main_load;

    exmem_slot #(.DBITS(DBITS), .RIB(REG_INDEX_BIT_WIDTH), .W(W)) u_main (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (main_load),
        .drain (consume),
        .d     (main_d),
`ifdef EXMEM_FWD_EN
        .wb_wrReg (wb_wrReg),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
`endif
        .q     (main_q),
        .valid (main_v)
    );

    exmem_slot #(.DBITS(DBITS), .RIB(REG_INDEX_BIT_WIDTH), .W(W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (skid_load),
        .drain (skid_drain),
        .d     (in_entry),
`ifdef EXMEM_FWD_EN
        .wb_wrReg (wb_wrReg),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
`endif
        .q     (skid_q),
        .valid (skid_v)
    );

    assign {EX_func, EX_op, EX_regData2, EX_intermediateResult, EX_rs2, EX_rd,
            EX_ME_mux_sel, wr_q, wm_q} = main_q;

    // Bubbles must never write; the remaining fields simply hold.
    assign out_valid = main_v;
    assign EX_wrReg  = wr_q && main_v;
    assign EX_wrMem  = wm_q && main_v;
endmodule

// File: tb/tb_exmem_skid_reg.sv
// Self-checking bench for exmem_skid_reg: directed table, corner sequences, randomized vs queue model.
module tb_exmem_skid_reg;
    import exmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  func, op, rs2, rd;
    logic [31:0] regData2, intermediateResult;
    logic        ME_mux_sel, wrReg, wrMem;
    logic [3:0]  EX_func, EX_op, EX_rs2, EX_rd;
    logic [31:0] EX_regData2, EX_intermediateResult;
    logic        EX_ME_mux_sel, EX_wrReg, EX_wrMem;
`ifdef EXMEM_FWD_EN
    logic        wb_wrReg;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exmem_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .op(op), .regData2(regData2), .intermediateResult(intermediateResult),
        .rs2(rs2), .rd(rd), .ME_mux_sel(ME_mux_sel), .wrReg(wrReg), .wrMem(wrMem),
`ifdef EXMEM_FWD_EN
        .wb_wrReg(wb_wrReg), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .EX_func(EX_func), .EX_op(EX_op), .EX_regData2(EX_regData2),
        .EX_intermediateResult(EX_intermediateResult), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
        .EX_ME_mux_sel(EX_ME_mux_sel), .EX_wrReg(EX_wrReg), .EX_wrMem(EX_wrMem)
    );

    entry_t act;
    assign act = {EX_func, EX_op, EX_regData2, EX_intermediateResult, EX_rs2, EX_rd,
                  EX_ME_mux_sel, EX_wrReg, EX_wrMem};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input entry_t e);
        {func, op, regData2, intermediateResult, rs2, rd, ME_mux_sel, wrReg, wrMem} = e;
    endtask

    function automatic entry_t tagged_entry(input logic [31:0] tag);
        entry_t e;
        e = '{func: ADD, op: ALUR, regData2: tag + 32'd1, intermediateResult: tag,
              rs2: 4'd1, rd: 4'd3, ME_mux_sel: 1'b1, wrReg: 1'b1, wrMem: 1'b1};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic        iv, ordy, fl;
        logic [31:0] tag;
        logic        e_ov, e_ir;
        logic [31:0] e_tag;
        logic        e_wr;
    } vec_t;

    vec_t        tbl[10];
    entry_t      q[$];
    entry_t      last, exp_e, e;
    logic        acc, cons;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
`ifdef EXMEM_FWD_EN
        wb_wrReg = 1'b0; wb_rd = '0; wb_data = '0;
`endif
        #2;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_fields", act, '0);
        @(posedge clk); #1;
        reset = 1'b1;

        // First transaction: exact field pass-through, one-cycle latency
        drive('{func: ADD, op: ALUR, regData2: 32'd2, intermediateResult: 32'd5,
                rs2: 4'd1, rd: 4'd3, ME_mux_sel: 1'b1, wrReg: 1'b1, wrMem: 1'b1});
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("first_out_valid", out_valid, 1'b1);
        chk("first_fields", act, {ADD, ALUR, 32'd2, 32'd5, 4'd1, 4'd3, 3'b111});

        //             iv    ordy  fl    tag     ov    ir    e_tag   wr
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd10, 1'b1, 1'b1, 32'd10, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'd11, 1'b1, 1'b1, 32'd11, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'd12, 1'b1, 1'b1, 32'd12, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'd99, 1'b0, 1'b1, 32'd12, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 1'b1, 32'd20, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'd21, 1'b1, 1'b0, 32'd20, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'd22, 1'b1, 1'b0, 32'd20, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'd99, 1'b1, 1'b1, 32'd21, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'd99, 1'b0, 1'b1, 32'd21, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'd99, 1'b0, 1'b1, 32'd21, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tagged_entry(tbl[i].tag));
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            step();
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_result", i), EX_intermediateResult, tbl[i].e_tag);
            chk($sformatf("tbl%0d_wr", i), {EX_wrReg, EX_wrMem}, {2{tbl[i].e_wr}});
        end

        // Flush with main=A, skid=B and C offered: everything squashed
        out_ready = 1'b0; in_valid = 1'b1;
        drive(tagged_entry(32'd30)); step();
        drive(tagged_entry(32'd31)); step();
        chk("pre_flush_in_ready", in_ready, 1'b0);
        drive(tagged_entry(32'd32)); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_wr_gated", {EX_wrReg, EX_wrMem}, 2'b00);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_data_hold", EX_intermediateResult, 32'd30);
        step();
        chk("post_flush_empty", out_valid, 1'b0);
        // Flush beats a real accept (skid empty, in_ready high)
        in_valid = 1'b1; drive(tagged_entry(32'd33)); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drops_accept", out_valid, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1; drive(tagged_entry(32'd34)); step();
        in_valid = 1'b0;
        chk("post_flush_new_valid", out_valid, 1'b1);
        chk("post_flush_new_tag", EX_intermediateResult, 32'd34);
        step();
        chk("post_flush_drained", out_valid, 1'b0);

        // Asynchronous reset with skid full
        out_ready = 1'b0; in_valid = 1'b1;
        drive(tagged_entry(32'd40)); step();
        drive(tagged_entry(32'd41)); step();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_fields", act, '0);
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        step();
        chk("no_stale_after_rst", out_valid, 1'b0);

        // Randomized run against an in-order queue model (at most 2 in flight)
        do_reset();
        q.delete(); last = '0;
        for (int c = 0; c < 400; c++) begin
            e = {$urandom, $urandom, $urandom};
            drive(e);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            acc  = in_valid && (q.size() < 2);
            cons = (q.size() > 0) && out_ready;
            step();
            if (flush) q.delete();
            else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            if (q.size() > 0) last = q[0];
            exp_e = last;
            if (q.size() == 0) begin exp_e.wrReg = 1'b0; exp_e.wrMem = 1'b0; end
            chk($sformatf("rnd%0d_out_valid", c), out_valid, q.size() > 0);
            chk($sformatf("rnd%0d_in_ready", c), in_ready, q.size() < 2);
            chk($sformatf("rnd%0d_fields", c), act, exp_e);
        end
        flush = 1'b0; in_valid = 1'b0;

`ifdef EXMEM_FWD_EN
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        drive('{func: ADD, op: ALUR, regData2: 32'd2, intermediateResult: 32'd5,
                rs2: 4'd1, rd: 4'd3, ME_mux_sel: 1'b0, wrReg: 1'b0, wrMem: 1'b1});
        step();
        in_valid = 1'b0;
        wb_wrReg = 1'b1; wb_rd = 4'd2; wb_data = 32'd9;
        step();
        chk("fwd_rd_miss", EX_regData2, 32'd2);
        wb_rd = 4'd1;
        step();
        chk("fwd_rd_hit", EX_regData2, 32'd9);
        wb_wrReg = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
